// File: rtl/tdm_demux_if.sv
// Bundle of the serial TDM input and the parallel frame output of tdm_demux.
// frame_cnt exists only when TDM_DEMUX_FRAME_CNT_EN is defined.
interface tdm_demux_if #(
  parameter int W = 8,
  parameter int N = 4
);
  localparam int SW = $clog2(N);

  logic           in_valid;
  logic           in_sof;
  logic [W-1:0]   in_data;
  logic [N*W-1:0] out_data;
  logic           out_valid;
  logic [SW-1:0]  slot;
  logic           busy;
  logic           frame_err;
`ifdef TDM_DEMUX_FRAME_CNT_EN
  logic [15:0]    frame_cnt;

  modport master (
    output in_valid, in_sof, in_data,
    input  out_data, out_valid, slot, busy, frame_err, frame_cnt
  );

  modport slave (
    input  in_valid, in_sof, in_data,
    output out_data, out_valid, slot, busy, frame_err, frame_cnt
  );
`else
  modport master (
    output in_valid, in_sof, in_data,
    input  out_data, out_valid, slot, busy, frame_err
  );

  modport slave (
    input  in_valid, in_sof, in_data,
    output out_data, out_valid, slot, busy, frame_err
  );
`endif
endinterface

// File: rtl/tdm_demux.sv
// TDM receiver: rebuilds one word per channel into a full frame and publishes it
// in parallel with a one-cycle valid pulse. Optional frame counter: TDM_DEMUX_FRAME_CNT_EN.
module tdm_demux #(
  parameter int W = 8,
  parameter int N = 4
) (
  input logic        clk,
  input logic        rst,
  tdm_demux_if.slave bus
);
  localparam int              SW        = $clog2(N);
  localparam logic [SW-1:0]   LAST_SLOT = SW'(N - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t         state_q;
  logic [SW-1:0]  slot_q;
  logic [W-1:0]   shadow_q [0:N-2];
  logic [N*W-1:0] out_data_q;
  logic           out_valid_q;
  logic           frame_err_q;
  logic           busy_q;
`ifdef TDM_DEMUX_FRAME_CNT_EN
  logic [15:0]    frame_cnt_q;
`endif

  // Slot N-1 is never stored: it goes straight into the published frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int k = 0; k < N - 1; k++) begin
        shadow_q[k] <= '0;
      end
`ifdef TDM_DEMUX_FRAME_CNT_EN
      frame_cnt_q <= '0;
`endif
    end else begin
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      if (bus.in_valid) begin
        case (state_q)
          IDLE: begin
            if (bus.in_sof) begin
              shadow_q[0] <= bus.in_data;
              slot_q      <= SW'(1);
              state_q     <= RUN;
              busy_q      <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
          RUN: begin
            if (bus.in_sof) begin
              // Early SOF restarts the frame; the partial one is dropped.
              frame_err_q <= 1'b1;
              shadow_q[0] <= bus.in_data;
              slot_q      <= SW'(1);
            end else if (slot_q == LAST_SLOT) begin
              for (int k = 0; k < N - 1; k++) begin
                out_data_q[k*W +: W] <= shadow_q[k];
              end
              out_data_q[(N-1)*W +: W] <= bus.in_data;
              out_valid_q <= 1'b1;
              slot_q      <= '0;
              state_q     <= IDLE;
              busy_q      <= 1'b0;
`ifdef TDM_DEMUX_FRAME_CNT_EN
              frame_cnt_q <= frame_cnt_q + 16'd1;
`endif
            end else begin
              for (int k = 0; k < N - 1; k++) begin
                if (slot_q == SW'(k)) begin
                  shadow_q[k] <= bus.in_data;
                end
              end
              slot_q <= slot_q + SW'(1);
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.slot      = slot_q;
  assign bus.busy      = busy_q;
  assign bus.frame_err = frame_err_q;
`ifdef TDM_DEMUX_FRAME_CNT_EN
  assign bus.frame_cnt = frame_cnt_q;
`endif

endmodule
